mem_port_arbiter: RTL and testbench

//  Shares one single-ported RAM between instruction fetch (PC side) and data

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported RAM between instruction fetch and data
//   load/store. Each access runs as a request/ack transaction on the RAM side.
//   Completion is reported to each requester as a one-cycle ready pulse.
//   Data has priority over fetch. An anti-starvation counter forces a fetch
//   grant after STARVE_LIMIT back-to-back data grants. A watchdog aborts any
//   access whose ram_ack never arrives.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   i_req/i_addr      fetch request (held until i_ready) and PC address
//   i_data/i_ready    fetched word, one-cycle completion pulse
//   d_ren/d_wen       data read / write request (held until d_ready)
//   d_addr/d_wdata    data address and store data
//   d_rdata/d_ready   load data, one-cycle completion pulse
//   ram_ren/ram_wen   RAM strobes, held for the whole access
//   ram_addr/ram_wdata RAM address and write data, stable during an access
//   ram_rdata/ram_ack RAM read data and one-cycle completion
//   busy              high while an access is outstanding
//   timeout           one-cycle pulse when the watchdog aborts an access
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              busy,
  output logic              timeout
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [SC_W-1:0]   starve_cnt, starve_n;
  logic [WD_W-1:0]   wd_cnt, wd_n;

  logic              ren_n, wen_n, busy_n, timeout_n, iready_n, dready_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, idata_n, drdata_n;

  logic d_any, i_pend, pick_d, pick_i, grant_d, grant_i, starve_ok;

  // Arbitration is decided on the raw request lines. A port whose ready pulse
  // is high still holds its (already served) request for this one cycle, so
  // it must not be issued again; if it is the winner the cycle simply idles.
  // Letting the loser jump ahead here would bypass the starvation counter.
  assign d_any     = d_ren | d_wen;
  assign i_pend    = i_req & ~i_ready;
  assign starve_ok = (starve_cnt < SC_W'(STARVE_LIMIT));
  assign pick_d    = d_any & (starve_ok | ~i_req);
  assign pick_i    = i_req & ~pick_d;
  assign grant_d   = pick_d & ~d_ready;
  assign grant_i   = pick_i & ~i_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n   = state;
    starve_n  = starve_cnt;
    wd_n      = wd_cnt;
    ren_n     = ram_ren;
    wen_n     = ram_wen;
    addr_n    = ram_addr;
    wdata_n   = ram_wdata;
    idata_n   = i_data;
    drdata_n  = d_rdata;
    busy_n    = busy;
    iready_n  = 1'b0;
    dready_n  = 1'b0;
    timeout_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_n = DATA;
          busy_n  = 1'b1;
          wd_n    = '0;
          addr_n  = d_addr;
          wdata_n = d_wdata;
          // A simultaneous read+write request is treated as a write only.
          wen_n   = d_wen;
          ren_n   = ~d_wen;
          if (i_pend)
            starve_n = (starve_cnt == SC_W'(STARVE_LIMIT)) ? starve_cnt
                                                           : starve_cnt + SC_W'(1);
          else
            starve_n = '0;
        end else if (grant_i) begin
          state_n  = FETCH;
          busy_n   = 1'b1;
          wd_n     = '0;
          addr_n   = i_addr;
          ren_n    = 1'b1;
          wen_n    = 1'b0;
          starve_n = '0;
        end
      end

      FETCH, DATA: begin
        if (ram_ack) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          if (state == FETCH) begin
            idata_n  = ram_rdata;
            iready_n = 1'b1;
          end else begin
            if (!ram_wen) drdata_n = ram_rdata;
            dready_n = 1'b1;
          end
        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          // Abort: the requester still holds its request and is reissued.
          state_n   = IDLE;
          busy_n    = 1'b0;
          ren_n     = 1'b0;
          wen_n     = 1'b0;
          timeout_n = 1'b1;
        end else begin
          wd_n = wd_cnt + WD_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wd_cnt     <= '0;
      ram_ren    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      i_data     <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      state      <= state_n;
      starve_cnt <= starve_n;
      wd_cnt     <= wd_n;
      ram_ren    <= ren_n;
      ram_wen    <= wen_n;
      ram_addr   <= addr_n;
      ram_wdata  <= wdata_n;
      i_data     <= idata_n;
      d_rdata    <= drdata_n;
      i_ready    <= iready_n;
      d_ready    <= dready_n;
      busy       <= busy_n;
      timeout    <= timeout_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Single-port accesses come from a
//   vector table; contention, starvation, watchdog and reset are driven as
//   hand-written sequences. The bench plays the RAM (ram_ack/ram_rdata).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_data;
  logic        i_ready;
  logic        d_ren = 1'b0;
  logic        d_wen = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ack = 1'b0;
  logic        busy;
  logic        timeout;

  int total = 0;
  int bad   = 0;
  int ip_cnt = 0;
  int dp_cnt = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Ready-pulse counters; sequences compare snapshots before and after.
  always @(posedge clk) begin
    if (i_ready) ip_cnt <= ip_cnt + 1;
    if (d_ready) dp_cnt <= dp_cnt + 1;
  end

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] rdata;
    int          k;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic        e_iready;
    logic        e_dready;
    logic [31:0] e_idata;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vec [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    while (!(ram_ren || ram_wen) && n < 40) begin
      tick();
      n++;
    end
    check({name, " strobe wait"}, 64'(n < 40), 64'd1);
  endtask

  task automatic drop_reqs();
    i_req = 1'b0;
    d_ren = 1'b0;
    d_wen = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " strobes"}, {62'd0, ram_ren, ram_wen}, 64'd0);
    check({name, " ready"},   {62'd0, i_ready, d_ready}, 64'd0);
    check({name, " busy/to"}, {62'd0, busy, timeout}, 64'd0);
    check({name, " ram_addr"}, 64'(ram_addr), 64'd0);
    check({name, " ram_wdata"}, 64'(ram_wdata), 64'd0);
    check({name, " data"}, {i_data, d_rdata}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ip0, dp0, n, writes;
    int exp_seq [7] = '{1, 1, 1, 1, 0, 1, 1};

    //             i  i_addr        ren wen d_addr        d_wdata       rdata         k  eren ewen e_addr        eir edr e_idata       e_drdata
    vec[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,        32'h0,  32'hDEADBEEF, 1, 1'b1, 1'b0, 32'h10,        1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    vec[1] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h200,      32'h0,  32'h12345678, 0, 1'b1, 1'b0, 32'h200,       1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678};
    vec[2] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h40,       32'h55, 32'hFFFFFFFF, 2, 1'b0, 1'b1, 32'h40,        1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678};
    vec[3] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,        32'h0,  32'hA5A5A5A5, 0, 1'b1, 1'b0, 32'h14,        1'b1, 1'b0, 32'hA5A5A5A5, 32'h12345678};
    vec[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h80,       32'h99, 32'h0BADF00D, 1, 1'b0, 1'b1, 32'h80,        1'b0, 1'b1, 32'hA5A5A5A5, 32'h12345678};
    vec[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,  32'hCAFEF00D, 3, 1'b1, 1'b0, 32'hFFFFFFFC,  1'b0, 1'b1, 32'hA5A5A5A5, 32'hCAFEF00D};

    // Power-on reset.
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single-port accesses from the table.
    for (int i = 0; i < 6; i++) begin
      i_req   = vec[i].i_req;
      i_addr  = vec[i].i_addr;
      d_ren   = vec[i].d_ren;
      d_wen   = vec[i].d_wen;
      d_addr  = vec[i].d_addr;
      d_wdata = vec[i].d_wdata;
      tick();
      check($sformatf("v%0d strobes", i), {62'd0, ram_ren, ram_wen},
            {62'd0, vec[i].e_ren, vec[i].e_wen});
      check($sformatf("v%0d ram_addr", i), 64'(ram_addr), 64'(vec[i].e_addr));
      check($sformatf("v%0d busy", i), 64'(busy), 64'd1);
      if (vec[i].e_wen)
        check($sformatf("v%0d ram_wdata", i), 64'(ram_wdata), 64'(vec[i].d_wdata));
      for (int c = 0; c < vec[i].k; c++) tick();
      check($sformatf("v%0d strobe hold", i), {62'd0, ram_ren, ram_wen},
            {62'd0, vec[i].e_ren, vec[i].e_wen});
      ram_ack   = 1'b1;
      ram_rdata = vec[i].rdata;
      tick();
      ram_ack   = 1'b0;
      ram_rdata = '0;
      check($sformatf("v%0d ready", i), {62'd0, i_ready, d_ready},
            {62'd0, vec[i].e_iready, vec[i].e_dready});
      check($sformatf("v%0d data", i), {i_data, d_rdata}, {vec[i].e_idata, vec[i].e_drdata});
      check($sformatf("v%0d idle", i), {61'd0, ram_ren, ram_wen, busy}, 64'd0);
      drop_reqs();
      tick();
      check($sformatf("v%0d pulse width", i), {62'd0, i_ready, d_ready}, 64'd0);
    end

    // Fetch and data load in the same cycle: data first, then the fetch.
    ip0 = ip_cnt;
    dp0 = dp_cnt;
    i_req = 1'b1; i_addr = 32'h100;
    d_ren = 1'b1; d_addr = 32'h200;
    tick();
    check("contend first addr", 64'(ram_addr), 64'h200);
    ram_ack = 1'b1; ram_rdata = 32'h11112222;
    tick();
    ram_ack = 1'b0;
    check("contend d_ready", {62'd0, i_ready, d_ready}, 64'd1);
    check("contend d_rdata", 64'(d_rdata), 64'h11112222);
    d_ren = 1'b0;
    tick();
    check("contend fetch addr", {31'd0, ram_ren, ram_addr}, {31'd0, 1'b1, 32'h100});
    ram_ack = 1'b1; ram_rdata = 32'h33334444;
    tick();
    ram_ack = 1'b0;
    check("contend i_ready", {62'd0, i_ready, d_ready}, 64'd2);
    check("contend i_data", 64'(i_data), 64'h33334444);
    i_req = 1'b0;
    tick();
    tick();
    check("contend pulse counts", {32'(ip_cnt - ip0), 32'(dp_cnt - dp0)}, {32'd1, 32'd1});

    // Held stores against a pending fetch: four writes, one fetch, then writes.
    d_wen = 1'b1; d_addr = 32'h40; d_wdata = 32'h55;
    i_req = 1'b1; i_addr = 32'h300;
    writes = 0;
    for (int a = 0; a < 7; a++) begin
      wait_strobe($sformatf("starve a%0d", a));
      check($sformatf("starve a%0d kind", a), 64'(ram_wen), 64'(exp_seq[a]));
      check($sformatf("starve a%0d addr", a), 64'(ram_addr),
            (exp_seq[a] == 1) ? 64'h40 : 64'h300);
      ram_ack = 1'b1; ram_rdata = 32'h300 + 32'(a);
      tick();
      ram_ack = 1'b0;
      check($sformatf("starve a%0d ready", a), {62'd0, i_ready, d_ready},
            (exp_seq[a] == 1) ? 64'd1 : 64'd2);
      if (d_ready) begin
        writes++;
        if (writes == 6) d_wen = 1'b0;
      end
      if (i_ready) i_req = 1'b0;
    end
    drop_reqs();
    check("starve data regs", {i_data, d_rdata}, {32'h304, 32'h11112222});
    tick();

    // Watchdog: no ack for TIMEOUT cycles, abort, reissue, then complete.
    d_ren = 1'b1; d_addr = 32'h500;
    wait_strobe("wd");
    n = 0;
    while (ram_ren && n < 40) begin
      n++;
      tick();
    end
    check("wd strobe cycles", 64'(n), 64'd16);
    check("wd timeout pulse", {61'd0, timeout, d_ready, busy}, 64'd4);
    check("wd d_rdata kept", 64'(d_rdata), 64'h11112222);
    tick();
    check("wd reissue", {31'd0, ram_ren, ram_addr}, {31'd0, 1'b1, 32'h500});
    check("wd timeout one cycle", 64'(timeout), 64'd0);
    ram_ack = 1'b1; ram_rdata = 32'h77778888;
    tick();
    ram_ack = 1'b0;
    check("wd d_ready", {62'd0, d_ready, timeout}, 64'd2);
    check("wd d_rdata", 64'(d_rdata), 64'h77778888);
    drop_reqs();
    tick();

    // Reset in the middle of a data access, then a stray late ack.
    dp0 = dp_cnt;
    d_ren = 1'b1; d_addr = 32'h600;
    wait_strobe("rst");
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("mid rst");
    d_ren = 1'b0;
    #2 rst = 1'b0;
    tick();
    ram_ack = 1'b1; ram_rdata = 32'hBBBBBBBB;
    tick();
    ram_ack = 1'b0;
    tick();
    check_all_zero("late ack");
    check("late ack pulses", 64'(dp_cnt - dp0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
